// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-port arbiter and transmitter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    PASS = 2'd2
  } arb_state_t;

  // Filler for the upper bytes of a tag word when words are wider than a byte.
  localparam logic [7:0] TAG_PAD = 8'h00;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // 4-bit value to its uppercase ASCII hex digit.
  function automatic logic [7:0] hex2ascii(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    else           return 8'h37 + {4'h0, v};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin find-first: first set request searching from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the result.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]        req,
  input  logic [idx_w(N_SRC)-1:0] last,
  output logic                    valid,
  output logic [idx_w(N_SRC)-1:0] idx
);

  localparam int IW = idx_w(N_SRC);

  logic [IW-1:0] cand;

  // Walk every position once, starting just after the previous owner.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = last;
    for (int i = 0; i < N_SRC; i++) begin
      cand = (cand == IW'(N_SRC - 1)) ? '0 : cand + 1'b1;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port among N_SRC producers, round-robin, one message per grant.
// Latency: 1 cycle IDLE->downstream request; data path is combinational (no register stage).
// Backpressure: m_wgnt=0 holds state and m_wdata; PASS stalls count toward the optional timeout.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int BYTE_WIDTH = 1,
  parameter int TAG_EN     = 1,
  parameter int MAX_BURST  = 64,
  parameter int TIMEOUT    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          s_wreq,
  input  logic [N_SRC-1:0]          s_wlast,
  input  logic [BYTE_WIDTH*8-1:0]   s_wdata [N_SRC],
  output logic [N_SRC-1:0]          s_wgnt,
  output logic                      m_wreq,
  input  logic                      m_wgnt,
  output logic [BYTE_WIDTH*8-1:0]   m_wdata,
  output logic                      busy,
  output logic [idx_w(N_SRC)-1:0]   cur_src
);

  localparam int DW = BYTE_WIDTH * 8;
  localparam int IW = idx_w(N_SRC);

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [31:0]   burst_cnt;
  logic [31:0]   stall_cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          xfer;
  logic [DW-1:0] tag_word;

  uart_rr_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .req   (s_wreq),
    .last  (last_owner),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Tag word: ASCII hex of the owner in byte 0, padding in every other byte.
  always_comb begin
    tag_word = '0;
    for (int b = 0; b < BYTE_WIDTH; b++) begin
      tag_word[b*8 +: 8] = TAG_PAD;
    end
    tag_word[7:0] = hex2ascii(4'(owner));
  end

  // Port steering: the owner is wired straight through to the transmitter while in PASS.
  always_comb begin
    m_wreq  = 1'b0;
    m_wdata = '0;
    s_wgnt  = '0;
    case (state)
      TAG: begin
        m_wreq  = 1'b1;
        m_wdata = tag_word;
      end
      PASS: begin
        m_wreq        = s_wreq[owner];
        m_wdata       = s_wdata[owner];
        s_wgnt[owner] = m_wgnt;
      end
      default: ;
    endcase
  end

  assign xfer    = (state == PASS) && s_wreq[owner] && m_wgnt;
  assign busy    = (state != IDLE);
  assign cur_src = owner;

  // Arbitration FSM: lock one source per message, release on last word, burst limit or stall timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(N_SRC - 1);
      burst_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            burst_cnt <= '0;
            stall_cnt <= '0;
            state     <= (TAG_EN != 0) ? TAG : PASS;
          end
        end
        TAG: begin
          if (m_wgnt) state <= PASS;
        end
        PASS: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 32'd1;
            stall_cnt <= '0;
            if (s_wlast[owner] || (burst_cnt == 32'(MAX_BURST - 1))) begin
              state      <= IDLE;
              last_owner <= owner;
            end
          end else begin
            stall_cnt <= stall_cnt + 32'd1;
            if ((TIMEOUT > 0) && (stall_cnt == 32'(TIMEOUT - 1))) begin
              state      <= IDLE;
              last_owner <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance a (MAX_BURST=64, no timeout), instance b (MAX_BURST=2, TIMEOUT=8).
// Latency: producers follow the selected instance's grants; downstream accepts whenever ds_ready is 1.
// Backpressure: ds_ready gates m_wgnt of both instances.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_wreq;
  logic [3:0] s_wlast;
  logic [7:0] s_wdata [4];
  logic       ds_ready;
  logic       sel_b;

  logic [3:0] a_sgnt, b_sgnt;
  logic       a_mreq, b_mreq, a_mgnt, b_mgnt;
  logic [7:0] a_mdat, b_mdat;
  logic       a_busy, b_busy;
  logic [1:0] a_cur, b_cur;

  logic [3:0] g_sel;
  logic       mreq_sel, mgnt_sel, busy_sel;
  logic [7:0] mdat_sel;

  logic [8:0] src_q [4][$];
  logic [7:0] cap_dat [$];
  int         cap_cyc [$];
  int         cap_src [$];
  bit         busy_h [4096];
  logic [3:0] xfer;
  logic [7:0] last_mdat;
  logic       last_mreq;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign a_mgnt   = a_mreq & ds_ready;
  assign b_mgnt   = b_mreq & ds_ready;
  assign g_sel    = sel_b ? b_sgnt : a_sgnt;
  assign mreq_sel = sel_b ? b_mreq : a_mreq;
  assign mgnt_sel = sel_b ? b_mgnt : a_mgnt;
  assign mdat_sel = sel_b ? b_mdat : a_mdat;
  assign busy_sel = sel_b ? b_busy : a_busy;

  uart_tx_arbiter #(.N_SRC(4), .BYTE_WIDTH(1), .TAG_EN(1), .MAX_BURST(64), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_wreq(s_wreq), .s_wlast(s_wlast), .s_wdata(s_wdata),
    .s_wgnt(a_sgnt), .m_wreq(a_mreq), .m_wgnt(a_mgnt), .m_wdata(a_mdat),
    .busy(a_busy), .cur_src(a_cur));

  uart_tx_arbiter #(.N_SRC(4), .BYTE_WIDTH(1), .TAG_EN(1), .MAX_BURST(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_wreq(s_wreq), .s_wlast(s_wlast), .s_wdata(s_wdata),
    .s_wgnt(b_sgnt), .m_wreq(b_mreq), .m_wgnt(b_mgnt), .m_wdata(b_mdat),
    .busy(b_busy), .cur_src(b_cur));

  function automatic int src_of(input logic [3:0] g);
    int r;
    r = -1;
    for (int s = 0; s < 4; s++) if (g[s]) r = s;
    return r;
  endfunction

  // Present the head of every producer queue.
  task automatic drive();
    logic [8:0] w;
    for (int s = 0; s < 4; s++) begin
      if (src_q[s].size() > 0) begin
        w          = src_q[s][0];
        s_wreq[s]  = 1'b1;
        s_wdata[s] = w[7:0];
        s_wlast[s] = w[8];
      end else begin
        s_wreq[s]  = 1'b0;
        s_wlast[s] = 1'b0;
        s_wdata[s] = 8'h00;
      end
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic last);
    src_q[s].push_back({last, d});
  endtask

  // One clock: observe at the falling edge, then advance producers just after the rising edge.
  task automatic step();
    @(negedge clk);
    xfer      = s_wreq & g_sel;
    last_mdat = mdat_sel;
    last_mreq = mreq_sel;
    if (mreq_sel && mgnt_sel) begin
      cap_dat.push_back(mdat_sel);
      cap_cyc.push_back(cyc);
      cap_src.push_back(src_of(g_sel));
    end
    if (cyc < 4096) busy_h[cyc] = busy_sel;
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < 4; s++)
      if (xfer[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
    drive();
  endtask

  task automatic clear_all();
    for (int s = 0; s < 4; s++) src_q[s].delete();
    cap_dat.delete();
    cap_cyc.delete();
    cap_src.delete();
    xfer = '0;
    drive();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ds_ready = 1'b1;
    clear_all();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_caps(input int n);
    for (int k = 0; k < 300 && cap_dat.size() < n; k++) step();
    checks++;
    if (cap_dat.size() < n) begin
      failures++;
      $display("FAIL wait_caps got=%0d words exp=%0d", cap_dat.size(), n);
    end
  endtask

  task automatic test_reset();
    sel_b = 1'b0;
    do_reset();
    checks++; if (a_mreq !== 1'b0)   begin failures++; $display("FAIL rst_m_wreq got=%b exp=0", a_mreq); end
    checks++; if (a_mdat !== 8'h00)  begin failures++; $display("FAIL rst_m_wdata got=%h exp=00", a_mdat); end
    checks++; if (a_sgnt !== 4'h0)   begin failures++; $display("FAIL rst_s_wgnt got=%b exp=0000", a_sgnt); end
    checks++; if (a_busy !== 1'b0)   begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
    checks++; if (a_cur !== 2'd0)    begin failures++; $display("FAIL rst_cur_src got=%0d exp=0", a_cur); end
    checks++; if (b_busy !== 1'b0)   begin failures++; $display("FAIL rst_b_busy got=%b exp=0", b_busy); end
  endtask

  task automatic test_single();
    logic [7:0] exp_d [4] = '{8'h30, 8'h41, 8'h42, 8'h43};
    logic [7:0] got;
    int p;
    sel_b = 1'b0;
    do_reset();
    p = cyc;
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    drive();
    wait_caps(4);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
      checks++;
      if (got !== exp_d[i]) begin failures++; $display("FAIL single_dat[%0d] got=%h exp=%h", i, got, exp_d[i]); end
      checks++;
      if (i < cap_cyc.size() && cap_cyc[i] !== p + 1 + i) begin
        failures++; $display("FAIL single_cyc[%0d] got=%0d exp=%0d", i, cap_cyc[i], p + 1 + i);
      end
    end
    checks++; if (busy_h[p+4] !== 1'b1) begin failures++; $display("FAIL single_busy_last got=%b exp=1", busy_h[p+4]); end
    checks++; if (busy_h[p+5] !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy_h[p+5]); end
    checks++; if (a_cur !== 2'd0) begin failures++; $display("FAIL single_cur_src got=%0d exp=0", a_cur); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [12] = '{8'h31, 8'hA1, 8'h33, 8'hC1, 8'h31, 8'hA2, 8'h33, 8'hC2,
                               8'h31, 8'hA3, 8'h33, 8'hC3};
    logic [7:0] got;
    int prev, twice, n3;
    sel_b = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(1, 8'hA1 + 8'(i), 1'b1);
      push(3, 8'hC1 + 8'(i), 1'b1);
    end
    drive();
    wait_caps(12);
    for (int i = 0; i < 12; i++) begin
      got = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
      checks++;
      if (got !== exp_d[i]) begin failures++; $display("FAIL rr_dat[%0d] got=%h exp=%h", i, got, exp_d[i]); end
    end
    prev = -1; twice = 0; n3 = 0;
    foreach (cap_src[i]) begin
      if (cap_src[i] >= 0) begin
        if (cap_src[i] == 3 && prev == 3) twice++;
        if (cap_src[i] == 3) n3++;
        prev = cap_src[i];
      end
    end
    checks++; if (twice !== 0) begin failures++; $display("FAIL rr_src3_repeat got=%0d exp=0", twice); end
    checks++; if (n3 !== 3)    begin failures++; $display("FAIL rr_src3_grants got=%0d exp=3", n3); end
  endtask

  task automatic test_atomicity();
    logic [7:0] exp_d [7] = '{8'h30, 8'h50, 8'h51, 8'h52, 8'h53, 8'h32, 8'h60};
    logic [7:0] got;
    sel_b = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 8'h50 + 8'(i), i == 3);
    drive();
    wait_caps(2);
    push(2, 8'h60, 1'b1);
    drive();
    wait_caps(7);
    for (int i = 0; i < 7; i++) begin
      got = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
      checks++;
      if (got !== exp_d[i]) begin failures++; $display("FAIL atom_dat[%0d] got=%h exp=%h", i, got, exp_d[i]); end
    end
    for (int i = 2; i < 5; i++) begin
      checks++;
      if (i < cap_cyc.size() && cap_cyc[i] !== cap_cyc[i-1] + 1) begin
        failures++; $display("FAIL atom_contig[%0d] got=%0d exp=%0d", i, cap_cyc[i], cap_cyc[i-1] + 1);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] exp_d [5] = '{8'h31, 8'h70, 8'h71, 8'h72, 8'h73};
    logic [7:0] got;
    int bad;
    sel_b = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 8'h70 + 8'(i), i == 3);
    drive();
    wait_caps(2);
    ds_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_mdat !== 8'h71 || last_mreq !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d bad cycles exp=0", bad); end
    checks++; if (cap_dat.size() !== 2) begin failures++; $display("FAIL bp_no_xfer got=%0d exp=2", cap_dat.size()); end
    ds_ready = 1'b1;
    wait_caps(5);
    for (int i = 0; i < 5; i++) begin
      got = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
      checks++;
      if (got !== exp_d[i]) begin failures++; $display("FAIL bp_dat[%0d] got=%h exp=%h", i, got, exp_d[i]); end
    end
  endtask

  task automatic test_burst_limit();
    logic [7:0] exp_d [8] = '{8'h32, 8'h80, 8'h81, 8'h32, 8'h82, 8'h83, 8'h32, 8'h84};
    logic [7:0] got;
    sel_b = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) push(2, 8'h80 + 8'(i), 1'b0);
    drive();
    wait_caps(8);
    for (int i = 0; i < 8; i++) begin
      got = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
      checks++;
      if (got !== exp_d[i]) begin failures++; $display("FAIL burst_dat[%0d] got=%h exp=%h", i, got, exp_d[i]); end
    end
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_timeout();
    logic [7:0] exp_d [4] = '{8'h30, 8'h90, 8'h31, 8'hA0};
    logic [7:0] got;
    int t;
    sel_b = 1'b1;
    do_reset();
    push(0, 8'h90, 1'b0);
    push(1, 8'hA0, 1'b1);
    drive();
    wait_caps(4);
    step();
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
      checks++;
      if (got !== exp_d[i]) begin failures++; $display("FAIL tmo_dat[%0d] got=%h exp=%h", i, got, exp_d[i]); end
    end
    t = (cap_cyc.size() > 1) ? cap_cyc[1] : 0;
    checks++; if (busy_h[t+8] !== 1'b1) begin failures++; $display("FAIL tmo_busy_held got=%b exp=1", busy_h[t+8]); end
    checks++; if (busy_h[t+9] !== 1'b0) begin failures++; $display("FAIL tmo_release got=%b exp=0", busy_h[t+9]); end
    checks++;
    if (cap_cyc.size() > 2 && cap_cyc[2] !== t + 10) begin
      failures++; $display("FAIL tmo_next_tag_cyc got=%0d exp=%0d", cap_cyc[2], t + 10);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d [4] = '{8'h30, 8'hE0, 8'h33, 8'hD0};
    logic [7:0] got;
    sel_b = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push(3, 8'hB0 + 8'(i), i == 3);
    drive();
    wait_caps(2);
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", a_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_mreq !== 1'b0)  begin failures++; $display("FAIL rmid_m_wreq got=%b exp=0", a_mreq); end
    checks++; if (a_mdat !== 8'h00) begin failures++; $display("FAIL rmid_m_wdata got=%h exp=00", a_mdat); end
    checks++; if (a_sgnt !== 4'h0)  begin failures++; $display("FAIL rmid_s_wgnt got=%b exp=0000", a_sgnt); end
    checks++; if (a_busy !== 1'b0)  begin failures++; $display("FAIL rmid_busy got=%b exp=0", a_busy); end
    checks++; if (a_cur !== 2'd0)   begin failures++; $display("FAIL rmid_cur_src got=%0d exp=0", a_cur); end
    clear_all();
    step();
    rst_n = 1'b1;
    step();
    push(3, 8'hD0, 1'b1);
    push(0, 8'hE0, 1'b1);
    drive();
    wait_caps(4);
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
      checks++;
      if (got !== exp_d[i]) begin failures++; $display("FAIL rmid_dat[%0d] got=%h exp=%h", i, got, exp_d[i]); end
    end
  endtask

  initial begin
    ds_ready = 1'b1;
    sel_b    = 1'b0;
    xfer     = '0;
    drive();
    test_reset();
    test_single();
    test_round_robin();
    test_atomicity();
    test_back_pressure();
    test_burst_limit();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single write port of the UART transmit FIFO among `N_SRC` independent message producers. Arbitration is round-robin with message atomicity: a granted source keeps the port until it flags the last word of its message, reaches the burst limit, or stalls past the timeout. An optional ASCII tag word identifying the source is injected before each message. The block sits between the producers and the `wreq/wgnt/wdata` port of the UART transmitter.

## Interface
- `N_SRC`, 4: number of requesters, 2..16.
- `BYTE_WIDTH`, 1: word width in bytes; must match the downstream transmitter.
- `TAG_EN`, 1: 1 inserts a tag word before each message; 0 disables tags.
- `MAX_BURST`, 64: maximum data words per grant, ≥1. The tag word is not counted.
- `TIMEOUT`, 0: maximum stall cycles in PASS before forced release; 0 disables the timeout.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `s_wreq`, in, `N_SRC`: per-source write request.
- `s_wlast`, in, `N_SRC`: per-source last-word flag, qualified by the transfer.
- `s_wdata`, in, `N_SRC`×`BYTE_WIDTH*8`: per-source data, unpacked array.
- `s_wgnt`, out, `N_SRC`: per-source grant; a word transfers in any cycle where it is 1.
- `m_wreq`, out, 1: request to the transmitter.
- `m_wgnt`, in, 1: grant from the transmitter. It is combinational from `m_wreq` and is only ever 1 when `m_wreq` is 1.
- `m_wdata`, out, `BYTE_WIDTH*8`: data to the transmitter.
- `busy`, out, 1: 1 while the state is TAG or PASS.
- `cur_src`, out, `$clog2(N_SRC)`: current or most recent owner.

## Operation
- Handshake, on both sides: the requester holds `req` and `data` stable until `gnt`. A transfer occurs in a cycle with `req && gnt`.
- State machine: IDLE, TAG, PASS.
- IDLE
  - `m_wreq`=0 and all `s_wgnt`=0.
  - If any `s_wreq` is set, pick the first requesting source searching from `last_owner+1` and wrapping modulo `N_SRC`.
  - Register the pick into `owner`, clear `burst_cnt` and `stall_cnt`.
  - Go to TAG if `TAG_EN`, otherwise go to PASS.
- TAG
  - `m_wreq`=1. `m_wdata` = hex2ascii(`owner`) in byte 0; all other bytes are 0x00.
  - Go to PASS on `m_wgnt`.
  - No source is granted while in TAG.
- PASS
  - `m_wreq` = `s_wreq[owner]` and `m_wdata` = `s_wdata[owner]`.
  - `s_wgnt[owner]` = `m_wgnt`; every other `s_wgnt` is 0.
  - On a transfer: `burst_cnt`++ and `stall_cnt` is cleared. If `s_wlast[owner]` is set or `burst_cnt`==`MAX_BURST`-1, go to IDLE and set `last_owner` = `owner`.
  - With no transfer: `stall_cnt`++. If `TIMEOUT`>0 and `stall_cnt`==`TIMEOUT`-1, go to IDLE and set `last_owner` = `owner`.
- Requests from non-owners are ignored until the block returns to IDLE. A source that drops `s_wreq` mid-message keeps the lock unless the timeout fires.
- A burst-limit release with `s_wlast`=0 ends the grant only. The source re-arbitrates, and its continuation receives a new tag.
- Counters are 32-bit, compared at full width.

## Timing
- Reset values:
  - state IDLE, `owner`=0, `last_owner`=`N_SRC`-1, so source 0 has first priority.
  - `m_wreq`=0, `m_wdata`=0, `s_wgnt`=0, `busy`=0, `cur_src`=0.
- `s_wgnt` and `m_wreq` in PASS are combinational from `m_wgnt` and `s_wreq`. There is no register stage in the data path.
- Arbitration latency:
  - 1 cycle from IDLE to the first downstream request.
  - With `TAG_EN`=1, the first data word can transfer at the earliest 2 cycles after the request is seen in IDLE.
- Return to IDLE takes 1 cycle after the releasing transfer. There are no back-to-back grants without passing through IDLE.
- Downstream full (`m_wgnt`=0): the block holds its state and `m_wdata` stable. Stall cycles count toward the timeout in PASS only, never in TAG.
- `N_SRC`=1: the wrap yields the same source every time.
- Reset asserted mid-message: return to reset values immediately. The partial message is not resumed.

## Structure
- Package `uart_tx_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, TAG, PASS};
  - function `hex2ascii` (4-bit value to ASCII '0'–'9'/'A'–'F'), shared with the transmitter;
  - constant `TAG_PAD` = 8'h00.
- Sub-module `uart_rr_pick`: a combinational round-robin find-first.
  - Inputs: `req[N_SRC]` and `last`.
  - Outputs: `valid` and `idx`.

## Test plan
- **Single source:** src0 sends 3 words 0x41,0x42,0x43 with `s_wlast` on the third, `m_wgnt` tied to `m_wreq` → downstream sees 0x30,0x41,0x42,0x43, `busy` falls 1 cycle after the last transfer, `cur_src`=0.
- **Round-robin:** src1 and src3 request continuously with 1-word messages → tags alternate 0x31,0x33,0x31,… and src3 is never granted twice in a row.
- **Atomicity:** src0 starts a 4-word message and src2 raises `s_wreq` after word 1 → all 4 src0 words are contiguous downstream, followed by tag 0x32.
- **Back-pressure:** `m_wgnt` is held 0 for 20 cycles mid-message with `TIMEOUT`=0 → `m_wdata` stays stable, no word is lost or duplicated, and transfers resume in order.
- **Burst limit and timeout:**
  - `MAX_BURST`=2 with an unterminated 5-word stream → 3 tagged grants of 2+2+1 words.
  - `TIMEOUT`=8 with the owner dropping `s_wreq` → release 8 stall cycles later, and the next source is granted.
- **Reset mid-message:** `rst_n` is pulsed low during PASS → all outputs return to reset values within the same cycle, and the next grant goes to src0 with a new tag.
